multi_clock_divider: RTL

Multi-channel, parametrised clock divider producing NCH independent divided clock levels and single-cycle tick strobes from one fast clock. It succeeds the single-channel clock cutter in the simulator's timing tree: one instance sets the fixed ratios between the logic, randomizer and display update domains. It adds run/pause gating, glitch-free factor changes at period boundaries, a global resynchronisation, and optional per-channel phase offsets.

---
 rtl/multi_clock_divider.sv | 92 +++++++++
 1 files changed

// File: rtl/multi_clock_divider.sv
// NCH independent divide-by-factor channels: level output plus one-cycle wrap strobe.
// Latency: all outputs registered, one edge after the sampled state; optional DIVIDER_PHASE_EN.
// Backpressure: none; run=0 freezes every channel, resync restarts all in lock-step.
module multi_clock_divider #(
    parameter int NCH = 4,
    parameter int N   = 32
) (
    input  logic             clk,
    input  logic             RESET_SIM_N,
    input  logic             run,
    input  logic             resync,
    input  logic [NCH*N-1:0] factor,
    input  logic [NCH*N-1:0] phase,
    output logic [NCH-1:0]   slow_clock,
    output logic [NCH-1:0]   tick
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0]   ctr_q   [NCH];
    logic [N-1:0]   f_q     [NCH];
    logic [N-1:0]   ctr_d   [NCH];
    logic [N-1:0]   f_d     [NCH];
    logic [N-1:0]   fac_w   [NCH];
    logic [N-1:0]   start_w [NCH];
    logic [NCH-1:0] sc_d;
    logic [NCH-1:0] tk_d;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        assign fac_w[g] = factor[g*N +: N];
`ifdef DIVIDER_PHASE_EN
        assign start_w[g] = (phase[g*N +: N] < fac_w[g]) ? phase[g*N +: N] : '0;
`else
        // Phase port is kept so both builds share one interface; its value is discarded.
        assign start_w[g] = phase[g*N +: N] & {N{1'b0}};
`endif
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ctr_d[i] = ctr_q[i];
            f_d[i]   = f_q[i];
            sc_d[i]  = slow_clock[i];
            tk_d[i]  = 1'b0;
            if (resync) begin
                ctr_d[i] = start_w[i];
                f_d[i]   = fac_w[i];
                sc_d[i]  = (start_w[i] < (fac_w[i] >> 1));
            end else if (run) begin
                if (f_q[i] == '0) begin
                    // Idle channel keeps sampling factor so a nonzero value starts it next edge.
                    ctr_d[i] = '0;
                    f_d[i]   = fac_w[i];
                    sc_d[i]  = 1'b0;
                end else if (f_q[i] == ONE) begin
                    ctr_d[i] = '0;
                    f_d[i]   = fac_w[i];
                    sc_d[i]  = 1'b0;
                    tk_d[i]  = 1'b1;
                end else if (ctr_q[i] == f_q[i] - ONE) begin
                    // Factor is only shadow-loaded at the wrap, so half-periods never shorten.
                    ctr_d[i] = '0;
                    f_d[i]   = fac_w[i];
                    tk_d[i]  = 1'b1;
                    sc_d[i]  = ('0 < (fac_w[i] >> 1));
                end else begin
                    ctr_d[i] = ctr_q[i] + ONE;
                    sc_d[i]  = ((ctr_q[i] + ONE) < (f_q[i] >> 1));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET_SIM_N) begin
            for (int i = 0; i < NCH; i++) begin
                ctr_q[i] <= '0;
                f_q[i]   <= fac_w[i];
            end
            slow_clock <= '0;
            tick       <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                ctr_q[i] <= ctr_d[i];
                f_q[i]   <= f_d[i];
            end
            slow_clock <= sc_d;
            tick       <= tk_d;
        end
    end

endmodule
